// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory arbiter.
//   size_e      - access size encoding carried on mX_size
//   is_illegal  - returns 1 for a misaligned address or an unusable size code
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } size_e;

  // Halfwords need an even address and words need a 4-byte boundary.
  // Bytes are always legal. Size code 11 has no meaning and is always rejected.
  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed lane out of the aligned RAM word and
// sign- or zero-extends it to the full data width.
//   rd          - aligned word read from the RAM
//   addr        - low two byte-address bits
//   size        - access size (size_e encoding)
//   is_unsigned - 1 = zero-extend, 0 = sign-extend (ignored for words)
//   data        - extended load result
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic [DATA_W-1:0] rd,
  input  logic [1:0]        addr,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [BYTE_W-1:0]   byte_lane;
  logic [2*BYTE_W-1:0] half_lane;
  logic                fill;

  // Lane selection: byte lane follows both address bits, the half lane
  // only follows addr[1] because odd halfword addresses never get here.
  always_comb begin
    byte_lane = '0;
    case (addr)
      2'd0: byte_lane = rd[0*BYTE_W +: BYTE_W];
      2'd1: byte_lane = rd[1*BYTE_W +: BYTE_W];
      2'd2: byte_lane = rd[2*BYTE_W +: BYTE_W];
      2'd3: byte_lane = rd[3*BYTE_W +: BYTE_W];
      default: byte_lane = '0;
    endcase
    half_lane = addr[1] ? rd[2*BYTE_W +: 2*BYTE_W] : rd[0 +: 2*BYTE_W];
  end

  // Extension: the fill bit is the lane's top bit unless zero-extension was asked for.
  always_comb begin
    data = '0;
    fill = 1'b0;
    case (size)
      SIZE_B: begin
        fill = is_unsigned ? 1'b0 : byte_lane[BYTE_W-1];
        data = {{(DATA_W-BYTE_W){fill}}, byte_lane};
      end
      SIZE_H: begin
        fill = is_unsigned ? 1'b0 : half_lane[2*BYTE_W-1];
        data = {{(DATA_W-2*BYTE_W){fill}}, half_lane};
      end
      SIZE_W:  data = rd;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin access controller placing two load/store
// requesters onto one byte-addressed data RAM port.
//   clk, rst_n            - clock, asynchronous active-low reset
//   mX_req/we/size/...    - request from requester X (0 = CPU LSU, 1 = DMA/debug)
//   mX_gnt                - combinational grant, request consumed this cycle
//   mX_rvalid/rdata/err   - registered response, one cycle after grant
//   ram_a/ram_wd          - RAM address and unshifted store data
//   ram_sb/ram_sh/ram_sw  - one-hot write strobes
//   ram_rd                - combinational aligned-word read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int WORD_LENGTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      m0_req,
  input  logic                      m0_we,
  input  logic [1:0]                m0_size,
  input  logic                      m0_unsigned,
  input  logic [ADDRESS_LENGTH-1:0] m0_addr,
  input  logic [ADDRESS_LENGTH-1:0] m0_wdata,
  output logic                      m0_gnt,
  output logic                      m0_rvalid,
  output logic [ADDRESS_LENGTH-1:0] m0_rdata,
  output logic                      m0_err,

  input  logic                      m1_req,
  input  logic                      m1_we,
  input  logic [1:0]                m1_size,
  input  logic                      m1_unsigned,
  input  logic [ADDRESS_LENGTH-1:0] m1_addr,
  input  logic [ADDRESS_LENGTH-1:0] m1_wdata,
  output logic                      m1_gnt,
  output logic                      m1_rvalid,
  output logic [ADDRESS_LENGTH-1:0] m1_rdata,
  output logic                      m1_err,

  output logic [ADDRESS_LENGTH-1:0] ram_a,
  output logic [ADDRESS_LENGTH-1:0] ram_wd,
  output logic                      ram_sb,
  output logic                      ram_sh,
  output logic                      ram_sw,
  input  logic [ADDRESS_LENGTH-1:0] ram_rd
);

  logic                      last_gnt;
  logic                      sel;
  logic                      grant_any;
  logic                      g_we;
  logic [1:0]                g_size;
  logic                      g_uns;
  logic [ADDRESS_LENGTH-1:0] g_addr;
  logic [ADDRESS_LENGTH-1:0] g_wdata;
  logic                      illegal;
  logic                      store_ok;
  logic [ADDRESS_LENGTH-1:0] load_data;
  logic [ADDRESS_LENGTH-1:0] resp_data;

  // Arbitration: on a tie the port that did not win last time goes next.
  // Grants are gated by rst_n so nothing is consumed while reset is held.
  always_comb begin
    sel = 1'b0;
    if (m0_req && m1_req) sel = ~last_gnt;
    else if (m1_req)      sel = 1'b1;
    grant_any = (m0_req | m1_req) & rst_n;
    m0_gnt    = grant_any & ~sel;
    m1_gnt    = grant_any &  sel;
  end

  // Request mux for the winning port.
  always_comb begin
    g_we    = sel ? m1_we       : m0_we;
    g_size  = sel ? m1_size     : m0_size;
    g_uns   = sel ? m1_unsigned : m0_unsigned;
    g_addr  = sel ? m1_addr     : m0_addr;
    g_wdata = sel ? m1_wdata    : m0_wdata;
  end

  // RAM drive: idle cycles park the bus at zero; illegal requests are
  // granted but never strobe.
  always_comb begin
    illegal  = is_illegal(g_size, g_addr[1:0]);
    ram_a    = grant_any ? g_addr  : '0;
    ram_wd   = grant_any ? g_wdata : '0;
    store_ok = grant_any & g_we & ~illegal;
    ram_sb   = store_ok & (g_size == SIZE_B);
    ram_sh   = store_ok & (g_size == SIZE_H);
    ram_sw   = store_ok & (g_size == SIZE_W);
  end

  dmem_load_align #(
    .DATA_W (ADDRESS_LENGTH),
    .BYTE_W (WORD_LENGTH)
  ) u_align (
    .rd          (ram_rd),
    .addr        (g_addr[1:0]),
    .size        (g_size),
    .is_unsigned (g_uns),
    .data        (load_data)
  );

  // Stores and rejected requests answer with zero data.
  always_comb begin
    resp_data = (g_we | illegal) ? '0 : load_data;
  end

  // Response registers capture the aligned load at the grant edge, which
  // keeps ram_rd off every output path. Reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m0_err    <= 1'b0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
      m1_err    <= 1'b0;
    end else begin
      m0_rvalid <= m0_gnt;
      m0_err    <= m0_gnt & illegal;
      m0_rdata  <= m0_gnt ? resp_data : '0;
      m1_rvalid <= m1_gnt;
      m1_err    <= m1_gnt & illegal;
      m1_rdata  <= m1_gnt ? resp_data : '0;
      if (grant_any) last_gnt <= sel;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a behavioural RAM.
// Drivers push the expected response when a grant is seen; a monitor pops
// and compares whenever a port presents rvalid.
module tb_dmem_arbiter;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m0_unsigned;
  logic [1:0]  m0_size;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_we, m1_unsigned;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_rdata;
  logic [31:0] ram_a, ram_wd, ram_rd;
  logic        ram_sb, ram_sh, ram_sw;

  logic [31:0] mem [0:1023];
  logic [9:0]  idx;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  dmem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_size     (m0_size),
    .m0_unsigned (m0_unsigned),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m0_err      (m0_err),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_size     (m1_size),
    .m1_unsigned (m1_unsigned),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .m1_err      (m1_err),
    .ram_a       (ram_a),
    .ram_wd      (ram_wd),
    .ram_sb      (ram_sb),
    .ram_sh      (ram_sh),
    .ram_sw      (ram_sw),
    .ram_rd      (ram_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: combinational aligned read, strobed write at the edge.
  assign idx    = ram_a[11:2];
  assign ram_rd = mem[idx];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_sw) mem[idx] <= ram_wd;
    else if (ram_sh) begin
      if (ram_a[1]) mem[idx][31:16] <= ram_wd[15:0];
      else          mem[idx][15:0]  <= ram_wd[15:0];
    end else if (ram_sb) begin
      case (ram_a[1:0])
        2'd0: mem[idx][7:0]   <= ram_wd[7:0];
        2'd1: mem[idx][15:8]  <= ram_wd[7:0];
        2'd2: mem[idx][23:16] <= ram_wd[7:0];
        default: mem[idx][31:24] <= ram_wd[7:0];
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive_fields(input int p, input logic req, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_size = size; m0_unsigned = uns; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_size = size; m1_unsigned = uns; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // Holds a request until granted, checks the RAM-side drive in the grant
  // cycle and queues the response the monitor should see next cycle.
  task automatic applyStimulus(input int p, input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [2:0] exp_strb, input logic [31:0] exp_rdata,
                               input logic exp_err);
    exp_t e;
    bit   done;
    done    = 1'b0;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    drive_fields(p, 1'b1, we, size, uns, addr, wdata);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if ((p == 0) ? m0_gnt : m1_gnt) begin
        done = 1'b1;
        checkOutput($sformatf("strobes p%0d @%h", p, addr), {29'b0, ram_sb, ram_sh, ram_sw}, {29'b0, exp_strb});
        checkOutput($sformatf("ram_a p%0d", p), ram_a, addr);
        checkOutput($sformatf("ram_wd p%0d", p), ram_wd, wdata);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout p%0d @%h actual=no_grant expected=grant", p, addr);
    end
    drive_fields(p, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: grant exclusivity every cycle, and a scoreboard pop per rvalid.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'h0);
      if (m0_rvalid) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL m0_unexpected_rvalid actual=1 expected=0");
        end else begin
          e = q0.pop_front();
          checkOutput("m0_rdata", m0_rdata, e.rdata);
          checkOutput("m0_err", {31'b0, m0_err}, {31'b0, e.err});
        end
      end
      if (m1_rvalid) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL m1_unexpected_rvalid actual=1 expected=0");
        end else begin
          e = q1.pop_front();
          checkOutput("m1_rdata", m1_rdata, e.rdata);
          checkOutput("m1_err", {31'b0, m1_err}, {31'b0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [1:0] tie_pat [4];

  initial begin
    tie_pat = '{2'b10, 2'b01, 2'b10, 2'b01};
    rst_n = 1'b0;
    drive_fields(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_fields(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #2;
    // Requests during reset must not be granted or strobe.
    drive_fields(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0);
    drive_fields(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10004, 32'h12345678);
    #10;
    checkOutput("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
    checkOutput("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
    checkOutput("rst_strobes", {29'b0, ram_sb, ram_sh, ram_sw}, 32'h0);
    checkOutput("rst_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    checkOutput("rst_err", {30'b0, m0_err, m1_err}, 32'h0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'h0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'h0);
    drive_fields(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    drive_fields(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b1;

    // Reset arriving right after a load grant drops the response.
    @(posedge clk); #1;
    drive_fields(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0);
    @(negedge clk);
    checkOutput("drop_gnt_before_reset", {31'b0, m0_gnt}, 32'h1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("drop_gnt_in_reset", {31'b0, m0_gnt}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("drop_rvalid", {31'b0, m0_rvalid}, 32'h0);
    end
    drive_fields(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #2 rst_n = 1'b1;

    // Both requesting from reset: m0, m1, m0, m1.
    @(posedge clk); #1;
    fork
      begin
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 3'b000, 32'h0, 1'b0);
        applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10004, 32'h0, 3'b000, 32'h0, 1'b0);
      end
      begin
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h10008, 32'h11111111, 3'b001, 32'h0, 1'b0);
        applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h1000C, 32'h22222222, 3'b001, 32'h0, 1'b0);
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk); #1;
          checkOutput($sformatf("tie_order_%0d", i), {30'b0, m0_gnt, m1_gnt}, {30'b0, tie_pat[i]});
        end
      end
    join

    // Word store / load round trip.
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10000, 32'hDEADBEEF, 3'b001, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h10008, 32'h0, 3'b000, 32'h11111111, 1'b0);

    // Byte loads with sign and zero extension.
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10000, 32'h000080FF, 3'b001, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h10001, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h10001, 32'h0, 3'b000, 32'h00000080, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 32'h10000, 32'h0, 3'b000, 32'hFFFFFFFF, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h10000, 32'h0, 3'b000, 32'h000000FF, 1'b0);

    // Halfword loads from both lanes; unsigned flag ignored for words.
    applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h10004, 32'h80010000, 3'b001, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'h10006, 32'h0, 3'b000, 32'hFFFF8001, 1'b0);
    applyStimulus(1, 1'b0, 2'b01, 1'b1, 32'h10006, 32'h0, 3'b000, 32'h00008001, 1'b0);
    applyStimulus(1, 1'b0, 2'b01, 1'b0, 32'h10004, 32'h0, 3'b000, 32'h00000000, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b1, 32'h10004, 32'h0, 3'b000, 32'h80010000, 1'b0);

    // Illegal accesses: granted, no strobe, err with zero data, RAM untouched.
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 32'h10002, 32'hFFFFFFFF, 3'b000, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 32'h10001, 32'h0, 3'b000, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 2'b11, 1'b0, 32'h10000, 32'hFFFFFFFF, 3'b000, 32'h0, 1'b1);
    applyStimulus(1, 1'b0, 2'b11, 1'b0, 32'h10000, 32'h0, 3'b000, 32'h0, 1'b1);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 3'b000, 32'h000080FF, 1'b0);

    // Sub-word stores from m1 land in the right lanes only.
    applyStimulus(1, 1'b1, 2'b00, 1'b0, 32'h10003, 32'h123456AB, 3'b100, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 3'b000, 32'hAB0080FF, 1'b0);
    applyStimulus(1, 1'b1, 2'b01, 1'b0, 32'h10002, 32'h9876CAFE, 3'b010, 32'h0, 1'b0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, 3'b000, 32'hCAFE80FF, 1'b0);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 32'h10003, 32'h0, 3'b000, 32'h000000CA, 1'b0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("q0_drained", q0.size(), 32'h0);
    checkOutput("q1_drained", q1.size(), 32'h0);
    checkOutput("idle_rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    checkOutput("idle_ram_a", ram_a, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
